// File: rtl/selen_wb_dma.sv
// selen_wb_dma: Wishbone pipelined master that copies len words from src to dst, one read then one write per word.
// Latency: 6 cycles per word with no stall and next-cycle ack; done_o pulses 6*N cycles after the start edge.
// Backpressure: each request is held stable while wb_stall_i=1; ack wait is bounded by TIMEOUT cycles (0 = unbounded).
module selen_wb_dma #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [AW-1:0]    src_addr_i,
    input  logic [AW-1:0]    dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [AW-1:0]    err_addr_o,
    output logic [AW-1:0]    wb_adr_o,
    output logic [DW-1:0]    wb_dat_o,
    output logic [DW/8-1:0]  wb_sel_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    input  logic [DW-1:0]    wb_dat_i,
    input  logic             wb_stall_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TMO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] STRIDE   = AW'(DW / 8);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_GAP, WR_REQ, WR_WAIT, WR_GAP
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     src_q;
    logic [AW-1:0]     dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [TW-1:0]     tmo_q;
    logic [AW-1:0]     adr_q;
    logic [DW-1:0]     dat_q;
    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [AW-1:0]     err_addr_q;

    logic              tmo_hit;
    logic              wait_abort;

    // A WAIT state aborts on a bus error (which beats a simultaneous ack) or when the ack budget runs out.
    assign tmo_hit    = TMO_EN && (tmo_q == TMO_LAST);
    assign wait_abort = wb_err_i || (!wb_ack_i && tmo_hit);

    // Copy sequencer: all bus and sideband outputs are registered here alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        src_q      <= src_addr_i;
                        dst_q      <= dst_addr_i;
                        rem_q      <= len_i;
                        err_q      <= 1'b0;
                        err_addr_q <= '0;
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RD_REQ;
                            busy_q  <= 1'b1;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b0;
                            adr_q   <= src_addr_i;
                        end
                    end
                end
                RD_REQ, WR_REQ: begin
                    if (!wb_stall_i) begin
                        stb_q   <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (wait_abort) begin
                        state_q    <= IDLE;
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        err_addr_q <= adr_q;
                        rem_q      <= '0;
                    end else if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        if (state_q == RD_WAIT) begin
                            dat_q   <= wb_dat_i;
                            state_q <= RD_GAP;
                        end else begin
                            src_q <= src_q + STRIDE;
                            dst_q <= dst_q + STRIDE;
                            rem_q <= rem_q - LEN_W'(1);
                            we_q  <= 1'b0;
                            if (rem_q == LEN_W'(1)) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= WR_GAP;
                            end
                        end
                    end else if (TMO_EN) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                // One idle bus cycle between read and write lets the crossbar re-decode the address.
                RD_GAP: begin
                    state_q <= WR_REQ;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                    adr_q   <= dst_q;
                end
                WR_GAP: begin
                    state_q <= RD_REQ;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b0;
                    adr_q   <= src_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = '1;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;

endmodule

// File: tb/tb_selen_wb_dma.sv
// tb_selen_wb_dma: randomized copies against a word-level reference model with a bus/event scoreboard.
// Latency: completion times are predicted from per-access stall and ack-delay plans.
// Backpressure: the bench slave applies planned stall cycles and checks request stability while stalled.
module tb_selen_wb_dma;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_dat_i;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    selen_wb_dma #(.AW(32), .DW(32), .LEN_W(16), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .src_addr_i (src_addr_i),
        .dst_addr_i (dst_addr_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_addr_o (err_addr_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_dat_i   (wb_dat_i),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        bit          is_err;
        int          t;
        logic [31:0] ea;
    } evt_t;

    bus_t exp_bus[$];
    evt_t exp_evt[$];
    int   plan_stall[$];
    int   plan_dly[$];
    int   plan_fault[$];

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int now     = 0;
    bit cyc_seen;
    bit busy_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) now++;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, now);
        end
    endtask

    // Reference model: word-by-word copy over a model memory; also plans the slave timing per access.
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int s_lo, input int s_hi, input int d_hi,
                         input int fidx, input int fkind);
        int          t;
        int          tot;
        bit          failed;
        logic [31:0] fa;
        logic [31:0] w;
        logic [31:0] a;
        bus_t        b;
        evt_t        e;
        t      = now + 1;
        tot    = (n == 0) ? 1 : 0;
        failed = 1'b0;
        fa     = '0;
        w      = '0;
        for (int i = 0; i < n && !failed; i++) begin
            for (int ph = 0; ph < 2 && !failed; ph++) begin
                int st;
                int dl;
                int f;
                a  = (ph == 0) ? s + 32'(4 * i) : d + 32'(4 * i);
                st = int'($urandom_range(s_hi, s_lo));
                dl = int'($urandom_range(d_hi, 0));
                f  = (2 * i + ph == fidx) ? fkind : 0;
                plan_stall.push_back(st);
                plan_dly.push_back(dl);
                plan_fault.push_back(f);
                b.we  = (ph == 1);
                b.adr = a;
                b.dat = w;
                exp_bus.push_back(b);
                if (f != 0) begin
                    failed = 1'b1;
                    fa     = a;
                    tot   += 3 + st + ((f == 2) ? (TMO - 1) : dl);
                end else begin
                    tot += 3 + st + dl;
                    if (ph == 0) w = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                    else         ref_mem[a] = w;
                end
            end
        end
        e.is_err = failed;
        e.t      = t + tot;
        e.ea     = fa;
        exp_evt.push_back(e);
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int s_lo, input int s_hi, input int d_hi,
                          input int fidx, input int fkind);
        @(negedge clk);
        issue(s, d, n, s_lo, s_hi, d_hi, fidx, fkind);
        src_addr_i = s;
        dst_addr_i = d;
        len_i      = 16'(n);
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("err_cleared_by_start", 32'(err_o), 32'd0);
        chk("busy_after_start", 32'(busy_o), 32'(n != 0));
    endtask

    task automatic flush();
        exp_bus.delete();
        exp_evt.delete();
        plan_stall.delete();
        plan_dly.delete();
        plan_fault.delete();
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        #1;
        while ((exp_evt.size() != 0 || busy_o) && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({nm, "_timeout"}, 32'(k >= 3000), 32'd0);
        chk({nm, "_bus_left"}, 32'(exp_bus.size()), 32'd0);
        flush();
    endtask

    // Bus slave and bus-side monitor: applies the plan, models memory, scores every accepted request.
    initial begin : slave
        bit          pend;
        int          pdly;
        int          pfault;
        logic        pwe;
        logic [31:0] padr;
        logic [31:0] pdat;
        bit          in_req;
        int          stall_left;
        logic        s_we;
        logic [31:0] s_adr;
        logic [31:0] s_dat;
        bus_t        e;
        pend = 0; pdly = 0; pfault = 0; pwe = 0; padr = '0; pdat = '0;
        in_req = 0; stall_left = 0; s_we = 0; s_adr = '0; s_dat = '0;
        forever begin
            @(negedge clk);
            wb_ack_i   = 1'b0;
            wb_err_i   = 1'b0;
            wb_stall_i = 1'b0;
            wb_dat_i   = $urandom;
            if (!rst_n || !wb_cyc_o) begin
                pend   = 0;
                in_req = 0;
            end
            if (!rst_n) continue;
            if (pend) begin
                if (pdly > 0) begin
                    pdly--;
                end else if (pfault != 2) begin
                    if (pfault == 1) begin
                        wb_err_i = 1'b1;
                        wb_ack_i = 1'($urandom_range(1, 0));
                    end else begin
                        wb_ack_i = 1'b1;
                        if (pwe) mem[padr] = pdat;
                        else     wb_dat_i  = mem_rd(padr);
                    end
                    pend = 0;
                end
            end else begin
                if ($urandom_range(7, 0) == 0) wb_ack_i = 1'b1;
                if (wb_cyc_o && wb_stb_o) begin
                    if (!in_req) begin
                        in_req     = 1;
                        stall_left = (plan_stall.size() != 0) ? plan_stall.pop_front() : 0;
                        s_we       = wb_we_o;
                        s_adr      = wb_adr_o;
                        s_dat      = wb_dat_o;
                    end else begin
                        chk("stall_adr_stable", wb_adr_o, s_adr);
                        chk("stall_we_stable", 32'(wb_we_o), 32'(s_we));
                        if (s_we) chk("stall_dat_stable", wb_dat_o, s_dat);
                    end
                    if (stall_left > 0) begin
                        wb_stall_i = 1'b1;
                        stall_left--;
                    end else begin
                        in_req = 0;
                        pend   = 1;
                        pdly   = (plan_dly.size() != 0) ? plan_dly.pop_front() : 0;
                        pfault = (plan_fault.size() != 0) ? plan_fault.pop_front() : 0;
                        pwe    = wb_we_o;
                        padr   = wb_adr_o;
                        pdat   = wb_dat_o;
                        if (exp_bus.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL bus_unexpected: got we=%0d adr=%h, required no access", pwe, padr);
                        end else begin
                            e = exp_bus.pop_front();
                            chk("bus_we", 32'(pwe), 32'(e.we));
                            chk("bus_adr", padr, e.adr);
                            chk("bus_sel", 32'(wb_sel_o), 32'hF);
                            if (e.we) chk("bus_wdat", pdat, e.dat);
                        end
                    end
                end
            end
        end
    end

    // Completion monitor: each done pulse or error rise must match the next predicted event.
    initial begin : evmon
        bit   err_prev;
        evt_t e;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                err_prev = 1'b0;
                continue;
            end
            if (wb_cyc_o) cyc_seen = 1'b1;
            if (busy_o)   busy_seen = 1'b1;
            if (done_o || (err_o && !err_prev)) begin
                if (exp_evt.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL evt_unexpected: got done=%0d err=%0d, required no completion at t=%0d",
                             done_o, err_o, now + 1);
                end else begin
                    e = exp_evt.pop_front();
                    chk("evt_kind", 32'({done_o, err_o & ~err_prev}), 32'({~e.is_err, e.is_err}));
                    chk("evt_time", 32'(now + 1), 32'(e.t));
                    chk("evt_busy_low", 32'(busy_o), 32'd0);
                    if (e.is_err) begin
                        chk("err_addr", err_addr_o, e.ea);
                        chk("err_cyc_low", 32'(wb_cyc_o), 32'd0);
                    end
                end
            end
            err_prev = err_o;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int k;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        src_addr_i = '0;
        dst_addr_i = '0;
        len_i      = '0;
        wb_dat_i   = '0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        cyc_seen   = 1'b0;
        busy_seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem[32'(4 * i)]     = 32'hA0 + 32'(i);
            ref_mem[32'(4 * i)] = 32'hA0 + 32'(i);
        end

        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_addr", err_addr_o, 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ROM -> RAM copy of four words, no stall, immediate ack: done exactly 24 cycles after start.
        launch(32'h0000_0000, 32'h0010_0000, 4, 0, 0, 0, -1, 0);
        wait_idle("copy4");
        for (int i = 0; i < 4; i++) chk("ram_word", mem_rd(32'h0010_0000 + 32'(4 * i)), 32'hA0 + 32'(i));

        // Zero-length start: done pulse only, no bus activity, never busy.
        cyc_seen  = 1'b0;
        busy_seen = 1'b0;
        launch(32'h0000_0100, 32'h0000_0200, 0, 0, 0, 0, -1, 0);
        wait_idle("len0");
        chk("len0_no_cyc", 32'(cyc_seen), 32'd0);
        chk("len0_no_busy", 32'(busy_seen), 32'd0);

        // Three stall cycles on every request.
        launch(32'h0000_0000, 32'h0010_0100, 2, 3, 3, 0, -1, 0);
        wait_idle("stall3");

        // Bus error on the second read (ack raised alongside at random), then a start clears err_o.
        launch(32'h0000_0040, 32'h0000_0300, 3, 0, 0, 0, 2, 1);
        wait_idle("rd_err");
        chk("err_sticky", 32'(err_o), 32'd1);
        launch(32'h0000_0000, 32'h0000_0400, 1, 0, 0, 0, -1, 0);
        wait_idle("after_err");

        // First write never acknowledged: timeout error at the destination address.
        launch(32'h0000_0000, 32'h0000_0500, 2, 0, 1, 0, 1, 2);
        wait_idle("timeout");

        // Start re-asserted with different arguments while busy must be ignored.
        launch(32'h0000_0000, 32'h0000_0600, 3, 0, 1, 1, -1, 0);
        repeat (3) @(negedge clk);
        src_addr_i = 32'h0000_0900;
        dst_addr_i = 32'h0000_0A00;
        len_i      = 16'd7;
        start_i    = 1'b1;
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        wait_idle("start_ignored");

        // Asynchronous reset while waiting for a write ack.
        launch(32'h0000_0000, 32'h0000_0700, 3, 0, 0, 2, -1, 0);
        k = 0;
        while (!(wb_cyc_o && wb_we_o && !wb_stb_o) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_wr_wait", 32'(k >= 200), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("arst_stb", 32'(wb_stb_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem = mem;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_cyc", 32'(wb_cyc_o), 32'd0);

        // Source address wraps from the top of the address space to zero.
        launch(32'hFFFF_FFFC, 32'h0000_3000, 2, 0, 0, 0, -1, 0);
        wait_idle("wrap");
        chk("wrap_word0", mem_rd(32'h0000_3000), dflt(32'hFFFF_FFFC));
        chk("wrap_word1", mem_rd(32'h0000_3004), 32'hA0);

        // Randomized copies with stalls, ack delays and occasional faults.
        for (int it = 0; it < 25; it++) begin
            int          n;
            int          fidx;
            int          fkind;
            logic [31:0] s;
            logic [31:0] d;
            n     = int'($urandom_range(6, 1));
            s     = 32'h0000_1000 + 32'(4 * $urandom_range(63, 0));
            d     = 32'h0000_2000 + 32'(4 * $urandom_range(63, 0));
            fidx  = -1;
            fkind = 0;
            if ($urandom_range(3, 0) == 0) begin
                fidx  = int'($urandom_range(2 * n - 1, 0));
                fkind = int'($urandom_range(2, 1));
            end
            launch(s, d, n, 0, int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), fidx, fkind);
            wait_idle("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
